activation_serializer: RTL

ACTIVATION_SERIALIZER -- requirements
Module: activation_serializer

---
 rtl/activation_serializer_pkg.sv | 16 +
 rtl/activation_serializer.sv | 93 +++++++++
 2 files changed

// File: rtl/activation_serializer_pkg.sv
// Shared NPU definitions for the activation serializer: default vector geometry and FSM state encoding.
`ifndef N
`define N 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package activation_serializer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/activation_serializer.sv
// Captures an N-element activation vector in one handshake, optionally clamps negatives to zero,
// and streams the elements out one per beat with index and last markers.
`ifndef N
`define N 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module activation_serializer
  import activation_serializer_pkg::*;
#(
  parameter int  N          = `N,
  parameter int  DATA_WIDTH = `DATA_WIDTH,
  parameter bit  RELU_EN    = 1'b1,
  localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DATA_WIDTH-1:0]      in_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]             out_index,
  output logic                         out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  ser_state_e                   state_q;
  logic [IDX_W-1:0]             idx_q;
  logic signed [DATA_WIDTH-1:0] buf_q [N];
  logic signed [DATA_WIDTH-1:0] outData_q;
  logic                         outLast_q;

  logic signed [DATA_WIDTH-1:0] act_d [N];
  logic [IDX_W-1:0]             nextIdx;
  logic                         beatDone;
  logic                         capture;

  // A new vector may be taken while the final element is leaving, which keeps back-to-back vectors bubble-free.
  assign beatDone = (state_q == STREAM) && out_ready;
  assign in_ready = (state_q == IDLE) || (beatDone && outLast_q);
  assign capture  = in_valid && in_ready;
  assign nextIdx  = idx_q + 1'b1;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      act_d[k] = (RELU_EN && in_vec[k*DATA_WIDTH + DATA_WIDTH - 1])
                 ? '0 : in_vec[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      outData_q <= '0;
      outLast_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= '0;
      end
    end else if (capture) begin
      state_q   <= STREAM;
      idx_q     <= '0;
      outData_q <= act_d[0];
      outLast_q <= (LAST_IDX == '0);
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= act_d[k];
      end
    end else if (beatDone) begin
      // Outputs are zeroed on the way back to IDLE so the idle bus reads as all-zero.
      if (outLast_q) begin
        state_q   <= IDLE;
        idx_q     <= '0;
        outData_q <= '0;
        outLast_q <= 1'b0;
      end else begin
        idx_q     <= nextIdx;
        outData_q <= buf_q[nextIdx];
        outLast_q <= (nextIdx == LAST_IDX);
      end
    end
  end

  assign out_valid = (state_q == STREAM);
  assign out_data  = outData_q;
  assign out_index = idx_q;
  assign out_last  = outLast_q;

endmodule
